fetch_unit: RTL and testbench

// - Instruction fetch stage; sits directly upstream of the decode unit.
// - Holds the PC and reads one instruction word from instruction memory over a req/valid handshake.
// - Presents the word to decode via compute_req/compute_valid, then updates the PC:

---
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_fetch_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: non-pipelined instruction fetch stage.
//
// Holds the PC, reads one instruction word from instruction memory, hands it
// to decode, then advances the PC (pc+4 or a decode-supplied target). Exactly
// one instruction is in flight at any time.
//
// Build option: define FETCH_ALIGN_CHECK_EN to trap misaligned taken targets
// (adds the fetch_fault port and the S_FAULT state). Without it, taken targets
// are silently forced to a 4-byte boundary.
//
// Handshake semantics (both interfaces are level-based req/valid):
//   - imem_req is held high with imem_addr stable for as long as the FSM is in
//     S_MEM_REQ; the first rising edge that sees imem_valid=1 completes the read
//     and captures imem_rdata. imem_valid outside S_MEM_REQ is ignored, except
//     that a high imem_valid in S_IDLE blocks a new request (stale response).
//   - compute_req is held high with inst stable for as long as the FSM is in
//     S_DECODE; the first rising edge that sees compute_valid=1 retires the
//     instruction and samples branch_flag/new_pc. The FSM then waits in
//     S_RELEASE until compute_valid returns low before it may fetch again.
//
// dbg_state exposes the FSM state register for observation.

module fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  // instruction memory
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_valid,
  // decode
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  compute_req,
  input  logic                  compute_valid,
  input  logic                  branch_flag,
  input  logic [DATA_WIDTH-1:0] new_pc,
  // status
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [CNT_WIDTH-1:0]  instret,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic                  fetch_fault,
`endif
  output logic [2:0]            dbg_state
);

  // State encoding is fixed so external observers can decode dbg_state.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEM_REQ = 3'd1,
    S_DECODE  = 3'd2,
    S_RELEASE = 3'd3
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    S_FAULT   = 3'd4
`endif
  } state_t;

  // Width used to bring new_pc to the address width regardless of which of
  // the two widths is larger (zero-extend or truncate).
  localparam int unsigned EXT_WIDTH = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [DATA_WIDTH-1:0]   inst_q;
  logic [CNT_WIDTH-1:0]    instret_q;
`ifdef FETCH_ALIGN_CHECK_EN
  logic                    fault_q;
`endif

  logic [EXT_WIDTH-1:0]    new_pc_ext;
  logic [ADDR_WIDTH-1:0]   target_d;
  logic [ADDR_WIDTH-1:0]   pc_inc_d;
  logic [ADDR_WIDTH-1:0]   pc_d;
  logic [CNT_WIDTH-1:0]    instret_d;
  logic                    misaligned_d;

  // Next-PC arithmetic: sequential pc+4 (wraps modulo 2^ADDR_WIDTH) or the
  // decode target brought to ADDR_WIDTH bits.
  always_comb begin
    new_pc_ext   = EXT_WIDTH'(new_pc);
    target_d     = new_pc_ext[ADDR_WIDTH-1:0];
    pc_inc_d     = pc_q + ADDR_WIDTH'(4);
    instret_d    = instret_q + CNT_WIDTH'(1);
    misaligned_d = 1'b0;
    pc_d         = pc_inc_d;
`ifdef FETCH_ALIGN_CHECK_EN
    // A taken target with low bits set is reported instead of followed.
    misaligned_d = branch_flag && (target_d[1:0] != 2'b00);
    if (branch_flag) begin
      pc_d = target_d;
    end
`else
    // Without the checker the low two bits of a taken target are dropped.
    if (branch_flag) begin
      pc_d = target_d & ~ADDR_WIDTH'(3);
    end
`endif
  end

  // Fetch FSM together with the PC, instruction, counter and fault registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      instret_q <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          // A response still high from earlier must drop before a new request.
          if (enable && !imem_valid) begin
            state_q <= S_MEM_REQ;
          end
        end
        S_MEM_REQ: begin
          if (imem_valid) begin
            inst_q  <= imem_rdata;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (compute_valid) begin
            if (misaligned_d) begin
`ifdef FETCH_ALIGN_CHECK_EN
              fault_q <= 1'b1;
              state_q <= S_FAULT;
`endif
            end else begin
              pc_q      <= pc_d;
              instret_q <= instret_d;
              state_q   <= S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          // Wait for decode to lower its done flag so it is not seen twice.
          if (!compute_valid) begin
            state_q <= S_IDLE;
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        S_FAULT: begin
          // Terminal until reset.
          state_q <= S_FAULT;
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded from the state register; reset clears them at once.
  always_comb begin
    imem_req    = (state_q == S_MEM_REQ);
    compute_req = (state_q == S_DECODE);
    imem_addr   = pc_q;
    inst        = inst_q;
    pc          = pc_q;
    instret     = instret_q;
    dbg_state   = state_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fetch_fault = fault_q;
`endif
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. A second instance with RESET_PC at the
// top of the address space shares all inputs to exercise PC wrap-around.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_fetch_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 32;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MEM_REQ = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_FAULT   = 3'd4;

  // clock / reset and shared stimulus
  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [DW-1:0] imem_rdata;
  logic          imem_valid;
  logic          compute_valid;
  logic          branch_flag;
  logic [DW-1:0] new_pc;

  // main instance outputs
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] inst;
  logic          compute_req;
  logic [AW-1:0] pc;
  logic [CW-1:0] instret;
  logic [2:0]    dbg_state;
  logic          fetch_fault;

  // wrap instance outputs
  logic          w_imem_req;
  logic [AW-1:0] w_imem_addr;
  logic [DW-1:0] w_inst;
  logic          w_compute_req;
  logic [AW-1:0] w_pc;
  logic [CW-1:0] w_instret;
  logic [2:0]    w_dbg_state;
  logic          w_fetch_fault;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(32'h0000_0000), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .inst(inst), .compute_req(compute_req), .compute_valid(compute_valid),
    .branch_flag(branch_flag), .new_pc(new_pc),
    .pc(pc), .instret(instret),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_fault(fetch_fault),
`endif
    .dbg_state(dbg_state)
  );

  fetch_unit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(32'hFFFF_FFFC), .CNT_WIDTH(CW)
  ) dut_w (
    .clk(clk), .rst(rst), .enable(enable),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .inst(w_inst), .compute_req(w_compute_req), .compute_valid(compute_valid),
    .branch_flag(branch_flag), .new_pc(new_pc),
    .pc(w_pc), .instret(w_instret),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_fault(w_fetch_fault),
`endif
    .dbg_state(w_dbg_state)
  );

`ifndef FETCH_ALIGN_CHECK_EN
  assign fetch_fault   = 1'b0;
  assign w_fetch_fault = 1'b0;
`endif

  // driver helpers
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one instruction from S_MEM_REQ with 1-cycle memory and decode
  // responses; returns with the FSM in S_IDLE.
  task automatic run_instr(input logic [DW-1:0] word, input logic br, input logic [DW-1:0] tgt);
    imem_valid = 1'b1;
    imem_rdata = word;
    tick();
    imem_valid    = 1'b0;
    compute_valid = 1'b1;
    branch_flag   = br;
    new_pc        = tgt;
    tick();
    compute_valid = 1'b0;
    branch_flag   = 1'b0;
    new_pc        = '0;
    tick();
  endtask

  // Watchdog: the directed sequence is bounded, this only guards a stuck sim.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; imem_rdata = '0; imem_valid = 1'b0;
    compute_valid = 1'b0; branch_flag = 1'b0; new_pc = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset state
    check("rst_pc",          pc, 32'h0);
    check("rst_instret",     instret, 32'h0);
    check("rst_inst",        inst, 32'h0);
    check("rst_imem_req",    imem_req, 1'b0);
    check("rst_compute_req", compute_req, 1'b0);
    check("rst_state",       dbg_state, ST_IDLE);
    check("rst_fault",       fetch_fault, 1'b0);
    check("rst_wrap_pc",     w_pc, 32'hFFFF_FFFC);

    // sequential instruction, memory answers 2 cycles after request
    enable = 1'b1;
    tick();
    check("seq_req",       imem_req, 1'b1);
    check("seq_addr",      imem_addr, 32'h0);
    tick();
    check("seq_req_hold",  imem_req, 1'b1);
    check("seq_addr_hold", imem_addr, 32'h0);
    imem_valid = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_valid = 1'b0; imem_rdata = 32'h0;
    check("seq_inst",        inst, 32'h0050_0093);
    check("seq_compute_req", compute_req, 1'b1);
    check("seq_req_drop",    imem_req, 1'b0);
    tick(); tick();
    check("seq_dec_wait",      dbg_state, ST_DECODE);
    check("seq_inst_stable",   inst, 32'h0050_0093);
    compute_valid = 1'b1; branch_flag = 1'b0;
    tick();
    check("seq_pc",            pc, 32'h4);
    check("seq_instret",       instret, 32'h1);
    check("seq_release_creq",  compute_req, 1'b0);
    check("wrap_pc",           w_pc, 32'h0);
    tick();
    check("seq_release_hold",  dbg_state, ST_RELEASE);
    compute_valid = 1'b0;
    tick();
    check("seq_idle",          dbg_state, ST_IDLE);
    tick();
    check("seq_next_addr",     imem_addr, 32'h4);
    check("seq_next_req",      imem_req, 1'b1);
    check("wrap_next_addr",    w_imem_addr, 32'h0);

    // second sequential instruction, pc 4 -> 8
    run_instr(32'h0010_8113, 1'b0, 32'h0);
    check("seq2_pc",      pc, 32'h8);
    check("seq2_instret", instret, 32'h2);
    tick();

    // taken branch at pc 8 -> 0x100
    check("br_from_addr", imem_addr, 32'h8);
    run_instr(32'h0F80_006F, 1'b1, 32'h100);
    check("br_instret",   instret, 32'h3);
    tick();
    check("br_req",       imem_req, 1'b1);
    check("br_addr",      imem_addr, 32'h100);

    // stall: drop enable during decode, instruction still completes
    imem_valid = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_valid = 1'b0;
    enable     = 1'b0;
    tick();
    check("stall_creq",    compute_req, 1'b1);
    compute_valid = 1'b1;
    tick();
    check("stall_pc",      pc, 32'h104);
    check("stall_instret", instret, 32'h4);
    tick();
    check("stall_release", dbg_state, ST_RELEASE);
    check("stall_rel_creq", compute_req, 1'b0);
    compute_valid = 1'b0;
    tick(); tick(); tick();
    check("stall_park",    dbg_state, ST_IDLE);
    check("stall_no_req",  imem_req, 1'b0);

    // stale memory response blocks the next request until it drops
    enable = 1'b1; imem_valid = 1'b1;
    tick();
    check("stale_no_req",  imem_req, 1'b0);
    check("stale_idle",    dbg_state, ST_IDLE);
    imem_valid = 1'b0;
    tick();
    check("stale_req",     imem_req, 1'b1);
    check("stale_addr",    imem_addr, 32'h104);

    // asynchronous reset between edges while imem_req is high
    #2;
    rst = 1'b1;
    #1;
    check("arst_req",     imem_req, 1'b0);
    check("arst_pc",      pc, 32'h0);
    check("arst_instret", instret, 32'h0);
    check("arst_inst",    inst, 32'h0);
    check("arst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    tick();
    rst = 1'b0;
    tick();
    check("arst_refetch", imem_addr, 32'h0);
    check("arst_req2",    imem_req, 1'b1);

    // compute_valid already high entering decode; taken misaligned target
    imem_valid = 1'b1; compute_valid = 1'b1; imem_rdata = 32'h1020_006F;
    tick();
    check("early_cv_decode", dbg_state, ST_DECODE);
    imem_valid = 1'b0; branch_flag = 1'b1; new_pc = 32'h102;
    tick();
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_fault",   fetch_fault, 1'b1);
    check("mis_pc",      pc, 32'h0);
    check("mis_instret", instret, 32'h0);
    check("mis_state",   dbg_state, ST_FAULT);
    compute_valid = 1'b0; branch_flag = 1'b0; new_pc = '0;
    tick(); tick();
    check("mis_no_req",  imem_req, 1'b0);
    check("mis_sticky",  fetch_fault, 1'b1);
`else
    check("mis_pc",      pc, 32'h100);
    check("mis_instret", instret, 32'h1);
    check("mis_state",   dbg_state, ST_RELEASE);
    compute_valid = 1'b0; branch_flag = 1'b0; new_pc = '0;
    tick(); tick();
    check("mis_req",     imem_req, 1'b1);
    check("mis_addr",    imem_addr, 32'h100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
